input_wrapper: RTL and testbench

//  Receive-side bus wrapper, mirroring the output wrapper. Collects NUM_WORDS words of

---
 rtl/input_wrapper_pkg.sv | 20 ++
 rtl/input_wrapper_if.sv | 39 +++
 rtl/input_wrapper_word_assembler.sv | 54 +++++
 rtl/input_wrapper.sv | 91 +++++++++
 tb/tb_input_wrapper.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/input_wrapper_pkg.sv
// Shared definitions for the receive-side bus wrapper.
// State encoding is 3 bits wide so it lines up with output_wrapper.
package input_wrapper_pkg;

    typedef enum logic [2:0] {
        WAIT_DATA  = 3'd0,
        LATCH      = 3'd1,
        HOLD_ACK   = 3'd2,
        START_CORE = 3'd3,
        WAIT_CORE  = 3'd4
    } state_e;

    localparam int WORD_W_DEF    = 8;
    localparam int NUM_WORDS_DEF = 4;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/input_wrapper_if.sv
// Producer/core signal bundle for input_wrapper.
// The master side is the producer plus core; the slave side is the wrapper.
interface input_wrapper_if #(
    parameter int WORD_W    = 8,
    parameter int NUM_WORDS = 4
);

    logic                          dataReady;
    logic [WORD_W-1:0]             inBus;
    logic                          gotData;
    logic                          start;
    logic                          coreDone;
    logic [WORD_W*NUM_WORDS-1:0]   operand;
    logic                          iBufferEmpty;
    logic                          iBufferFull;

    modport master (
        output dataReady,
        output inBus,
        output coreDone,
        input  gotData,
        input  start,
        input  operand,
        input  iBufferEmpty,
        input  iBufferFull
    );

    modport slave (
        input  dataReady,
        input  inBus,
        input  coreDone,
        output gotData,
        output start,
        output operand,
        output iBufferEmpty,
        output iBufferFull
    );

endinterface

// File: rtl/input_wrapper_word_assembler.sv
// Word counter and operand slice register for input_wrapper.
// load writes din into slice[count]; clear only rewinds the counter.
module word_assembler
    import input_wrapper_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int NUM_WORDS = 4,
    parameter int CW        = cnt_w(NUM_WORDS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic                        clear,
    input  logic [WORD_W-1:0]           din,
    output logic [CW-1:0]               count,
    output logic [WORD_W*NUM_WORDS-1:0] operand
);

    localparam int OP_W = WORD_W * NUM_WORDS;

    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [OP_W-1:0] operand_q;
    logic [OP_W-1:0] operand_d;

    always_comb begin
        count_d   = count_q;
        operand_d = operand_q;
        if (clear) begin
            count_d = '0;
        end else if (load && (count_q < CW'(NUM_WORDS))) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (count_q == CW'(i)) begin
                    operand_d[i*WORD_W +: WORD_W] = din;
                end
            end
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            operand_q <= '0;
        end else begin
            count_q   <= count_d;
            operand_q <= operand_d;
        end
    end

    assign count   = count_q;
    assign operand = operand_q;

endmodule

// File: rtl/input_wrapper.sv
// Receive-side bus wrapper: gathers NUM_WORDS words over a 4-phase
// handshake, then hands the assembled operand to the core.
module input_wrapper
    import input_wrapper_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int NUM_WORDS = NUM_WORDS_DEF
) (
    input logic            clk,
    input logic            rst,
    input_wrapper_if.slave bus
);

    localparam int CW = cnt_w(NUM_WORDS);

    state_e          state_q;
    state_e          state_d;
    logic [CW-1:0]   count;
    logic            load;
    logic            clear;
    logic            got_data;
    logic            start;
    logic            buf_empty;
    logic            buf_full;

    word_assembler #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .CW        (CW)
    ) u_asm (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .clear   (clear),
        .din     (bus.inBus),
        .count   (count),
        .operand (bus.operand)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WAIT_DATA;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_DATA: begin
                if (bus.dataReady) state_d = LATCH;
            end
            LATCH: begin
                state_d = HOLD_ACK;
            end
            HOLD_ACK: begin
                // ack is held until the producer drops its request
                if (!bus.dataReady) begin
                    state_d = (count == CW'(NUM_WORDS)) ?
                              START_CORE : WAIT_DATA;
                end
            end
            START_CORE: begin
                state_d = WAIT_CORE;
            end
            WAIT_CORE: begin
                if (bus.coreDone) state_d = WAIT_DATA;
            end
            default: begin
                state_d = WAIT_DATA;
            end
        endcase
    end

    always_comb begin
        got_data  = (state_q == HOLD_ACK);
        start     = (state_q == START_CORE);
        buf_full  = (state_q == START_CORE) ||
                    (state_q == WAIT_CORE);
        buf_empty = (state_q == WAIT_DATA) && (count == '0);
        load      = (state_q == LATCH);
        clear     = (state_q == WAIT_CORE) && bus.coreDone;
    end

    assign bus.gotData      = got_data;
    assign bus.start        = start;
    assign bus.iBufferEmpty = buf_empty;
    assign bus.iBufferFull  = buf_full;

endmodule

// File: tb/tb_input_wrapper.sv
// Randomized self-checking bench for input_wrapper.
// The model tracks expected slices as a plain array indexed by word order.
module tb_input_wrapper;

    localparam int WW = 8;
    localparam int NW = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    input_wrapper_if #(.WORD_W(WW), .NUM_WORDS(NW)) bus ();

    input_wrapper #(.WORD_W(WW), .NUM_WORDS(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [WW-1:0] exp_sl [NW];
    int widx = 0;
    logic [WW-1:0] nxt;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_op();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < NW; i++) r[i*WW +: WW] = exp_sl[i];
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NW; i++) exp_sl[i] = '0;
        widx = 0;
    endtask

    task automatic send_word(input logic [WW-1:0] w, input int extra);
        int n;
        bus.inBus     = w;
        bus.dataReady = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.gotData && n < 20);
        check("ack_rise", 64'(bus.gotData), 64'd1);
        check("ack_lat", 64'(n), 64'd2);
        if (widx < NW) begin
            exp_sl[widx] = w;
            widx++;
        end
        check("op_word", 64'(bus.operand), exp_op());
        check("empty_busy", 64'(bus.iBufferEmpty), 64'd0);
        repeat (extra) begin
            bus.inBus = WW'($urandom);
            @(negedge clk);
            check("ack_hold", 64'(bus.gotData), 64'd1);
        end
        bus.dataReady = 1'b0;
        @(negedge clk);
        check("ack_fall", 64'(bus.gotData), 64'd0);
        check("op_stable", 64'(bus.operand), exp_op());
    endtask

    task automatic end_operand(input bit cd_in_start, input int delay,
                               input bit overlap, input logic [WW-1:0] nw);
        check("start_pulse", 64'(bus.start), 64'd1);
        check("full_start", 64'(bus.iBufferFull), 64'd1);
        check("op_full", 64'(bus.operand), exp_op());
        if (cd_in_start) bus.coreDone = 1'b1;
        @(negedge clk);
        bus.coreDone = 1'b0;
        check("start_once", 64'(bus.start), 64'd0);
        check("full_wait", 64'(bus.iBufferFull), 64'd1);
        if (overlap) begin
            bus.inBus     = nw;
            bus.dataReady = 1'b1;
        end
        repeat (delay) begin
            @(negedge clk);
            check("wait_noack", 64'(bus.gotData), 64'd0);
            check("wait_full", 64'(bus.iBufferFull), 64'd1);
            check("wait_op", 64'(bus.operand), exp_op());
        end
        bus.coreDone = 1'b1;
        @(negedge clk);
        bus.coreDone = 1'b0;
        widx = 0;
        check("full_clr", 64'(bus.iBufferFull), 64'd0);
        check("empty_clr", 64'(bus.iBufferEmpty), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst           = 1'b0;
        bus.dataReady = 1'b0;
        bus.coreDone  = 1'b0;
        bus.inBus     = '0;
        clear_model();
        #3;
        check("rst_ack", 64'(bus.gotData), 64'd0);
        check("rst_start", 64'(bus.start), 64'd0);
        check("rst_empty", 64'(bus.iBufferEmpty), 64'd1);
        check("rst_full", 64'(bus.iBufferFull), 64'd0);
        check("rst_op", 64'(bus.operand), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        send_word(8'h5A, 0);
        send_word(8'hC3, 1);
        bus.inBus     = 8'h77;
        bus.dataReady = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.gotData && n < 20);
        check("mid_ack", 64'(bus.gotData), 64'd1);
        #2 rst = 1'b0;
        #1;
        clear_model();
        check("arst_ack", 64'(bus.gotData), 64'd0);
        check("arst_empty", 64'(bus.iBufferEmpty), 64'd1);
        check("arst_op", 64'(bus.operand), 64'd0);
        check("arst_full", 64'(bus.iBufferFull), 64'd0);
        bus.dataReady = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_empty", 64'(bus.iBufferEmpty), 64'd1);

        send_word(8'h11, 0);
        send_word(8'h22, 5);
        send_word(8'h33, 0);
        send_word(8'h44, 0);
        check("op_dir", 64'(bus.operand), 64'h44332211);
        end_operand(1'b1, 10, 1'b1, 8'hAA);

        send_word(8'hAA, 0);
        check("slice0_aa", 64'(bus.operand[7:0]), 64'hAA);
        check("upper_keep", 64'(bus.operand[31:8]), 64'h443322);
        for (int i = 1; i < NW; i++) send_word(WW'($urandom), 0);
        nxt = WW'($urandom);
        end_operand(1'b0, 0, 1'b1, nxt);

        for (int op = 0; op < 30; op++) begin
            int extra;
            extra = int'($urandom_range(0, 3));
            send_word(nxt, extra);
            for (int i = 1; i < NW; i++) begin
                send_word(WW'($urandom), int'($urandom_range(0, 3)));
            end
            nxt = WW'($urandom);
            end_operand(1'($urandom), int'($urandom_range(0, 5)),
                        1'($urandom), nxt);
        end
        bus.dataReady = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
